// File: rtl/cpu_pkg.sv
// Shared definitions for the 8-bit RISC CPU: opcode encodings used by the
// fetch unit and the controller, and the fetch-stage state encoding.
package cpu_pkg;

    localparam int unsigned OPCODE_W = 3;

    localparam logic [OPCODE_W-1:0] HLT = 3'd0;
    localparam logic [OPCODE_W-1:0] SKZ = 3'd1;
    localparam logic [OPCODE_W-1:0] ADD = 3'd2;
    localparam logic [OPCODE_W-1:0] AND = 3'd3;
    localparam logic [OPCODE_W-1:0] XOR = 3'd4;
    localparam logic [OPCODE_W-1:0] LDA = 3'd5;
    localparam logic [OPCODE_W-1:0] STO = 3'd6;
    localparam logic [OPCODE_W-1:0] JMP = 3'd7;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FETCH  = 2'd1,
        HOLD   = 2'd2,
        HALTED = 2'd3
    } fetch_state_t;

endpackage

// File: rtl/fetch_pc.sv
// Program counter register for the fetch stage. All increments wrap modulo
// 2^ADDR_W. Priority: load > inc2 > inc.
//   clk, rst_n : clock, async active-low reset (pc clears to 0)
//   inc        : pc <= pc + 1
//   inc2       : pc <= pc + 2
//   load       : pc <= load_val
//   load_val   : jump target
//   pc         : current program counter
module fetch_pc #(
    parameter int unsigned ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              inc,
    input  logic              inc2,
    input  logic              load,
    input  logic [ADDR_W-1:0] load_val,
    output logic [ADDR_W-1:0] pc
);

    // Natural overflow of the ADDR_W-bit add provides the wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc <= '0;
        end else if (load) begin
            pc <= load_val;
        end else if (inc2) begin
            pc <= pc + ADDR_W'(2);
        end else if (inc) begin
            pc <= pc + ADDR_W'(1);
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, fetches one instruction byte per
// req/ack transaction into the IR, offers it to the controller over
// valid/ready, and resolves JMP/SKZ/HLT on the retire edge.
// Optional macro FETCH_TIMEOUT_EN: memory ack timeout that raises a sticky
// fault and halts; without it fault is tied 0 and FETCH waits forever.
// Ports:
//   clk, rst_n            : clock, async active-low reset
//   mem_req, mem_addr     : fetch request / address (address = pc)
//   mem_rdata, mem_ack    : instruction byte and response
//   instr_valid/ready     : IR handshake with the controller
//   opcode, operand       : IR fields
//   acc_zero              : accumulator zero flag, sampled at SKZ retire
//   resume                : leave HALTED
//   halted, fault, pc     : status and debug
module fetch_unit
    import cpu_pkg::*;
#(
    parameter int unsigned ADDR_W         = 5,
    parameter int unsigned DATA_W         = 8,
    parameter int unsigned TIMEOUT_CYCLES = 15
) (
    input  logic                clk,
    input  logic                rst_n,
    output logic                mem_req,
    output logic [ADDR_W-1:0]   mem_addr,
    input  logic [DATA_W-1:0]   mem_rdata,
    input  logic                mem_ack,
    output logic                instr_valid,
    input  logic                instr_ready,
    output logic [OPCODE_W-1:0] opcode,
    output logic [ADDR_W-1:0]   operand,
    input  logic                acc_zero,
    input  logic                resume,
    output logic                halted,
    output logic                fault,
    output logic [ADDR_W-1:0]   pc
);

    if (TIMEOUT_CYCLES == 0) begin : g_bad_cfg
        $error("fetch_unit: TIMEOUT_CYCLES must be nonzero");
    end

    fetch_state_t        state_q, state_d;
    logic [DATA_W-1:0]   ir_q;
    logic                ir_load;
    logic                pc_inc;
    logic                pc_load;
    logic                timeout_c;

    // PC register; the +2 path is not needed because SKZ skips from an
    // already-incremented pc.
    fetch_pc #(
        .ADDR_W (ADDR_W)
    ) u_pc (
        .clk      (clk),
        .rst_n    (rst_n),
        .inc      (pc_inc),
        .inc2     (1'b0),
        .load     (pc_load),
        .load_val (operand),
        .pc       (pc)
    );

`ifdef FETCH_TIMEOUT_EN
    localparam int unsigned WAIT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [WAIT_W-1:0] wait_q;
    logic              fault_q;

    // Counts un-acked FETCH cycles; held at 0 outside FETCH so it is clear on entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_q <= '0;
        end else if (state_q != FETCH) begin
            wait_q <= '0;
        end else if (!mem_ack) begin
            wait_q <= wait_q + WAIT_W'(1);
        end
    end

    // The edge that would complete the TIMEOUT_CYCLES-th wait cycle times out.
    assign timeout_c = (state_q == FETCH) && !mem_ack &&
                       (wait_q == WAIT_W'(TIMEOUT_CYCLES - 1));

    // Sticky until reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fault_q <= 1'b0;
        end else if (timeout_c) begin
            fault_q <= 1'b1;
        end
    end

    assign fault = fault_q;
`else
    assign timeout_c = 1'b0;
    assign fault     = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and datapath control.
    always_comb begin
        state_d = state_q;
        ir_load = 1'b0;
        pc_inc  = 1'b0;
        pc_load = 1'b0;
        unique case (state_q)
            IDLE: begin
                state_d = FETCH;
            end
            FETCH: begin
                if (mem_ack) begin
                    ir_load = 1'b1;
                    pc_inc  = 1'b1;
                    state_d = HOLD;
                end else if (timeout_c) begin
                    state_d = HALTED;
                end
            end
            HOLD: begin
                if (instr_ready) begin
                    state_d = FETCH;
                    unique case (opcode)
                        JMP:     pc_load = 1'b1;
                        SKZ:     pc_inc  = acc_zero;
                        HLT:     state_d = HALTED;
                        default: ;
                    endcase
                end
            end
            HALTED: begin
                if (resume && !fault) begin
                    state_d = FETCH;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Instruction register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ir_q <= '0;
        end else if (ir_load) begin
            ir_q <= mem_rdata;
        end
    end

    // Outputs decoded from registered state only.
    assign mem_req     = (state_q == FETCH);
    assign mem_addr    = pc;
    assign instr_valid = (state_q == HOLD);
    assign halted      = (state_q == HALTED);
    assign opcode      = ir_q[DATA_W-1 -: OPCODE_W];
    assign operand     = ir_q[ADDR_W-1:0];

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: a program-memory responder drives
// fetches; expected IR contents are queued when each byte is returned and
// compared when the instruction is presented.
module tb_fetch_unit;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       mem_req;
    logic [4:0] mem_addr;
    logic [7:0] mem_rdata;
    logic       mem_ack;
    logic       instr_valid;
    logic       instr_ready;
    logic [2:0] opcode;
    logic [4:0] operand;
    logic       acc_zero;
    logic       resume;
    logic       halted;
    logic       fault;
    logic [4:0] pc;

    typedef struct {
        logic [2:0] op;
        logic [4:0] opd;
    } exp_t;

    exp_t       exp_q[$];
    logic [7:0] mem [32];
    int         n_cmp = 0;
    int         n_err = 0;
    int         cyc = 0;
    int         last_cyc = 0;

    fetch_unit dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .mem_rdata   (mem_rdata),
        .mem_ack     (mem_ack),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .opcode      (opcode),
        .operand     (operand),
        .acc_zero    (acc_zero),
        .resume      (resume),
        .halted      (halted),
        .fault       (fault),
        .pc          (pc)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check(tag, {mem_req, mem_addr, instr_valid, opcode, operand, halted, fault, pc}, 32'd0);
    endtask

    // One full fetch/retire transaction at the expected address.
    task automatic step(input logic [4:0] addr, input int waits, input int rdelay,
                        input logic acc, input bit chk_tp);
        int n;
        exp_t e;
        logic [4:0] nxt;
        n = 0;
        while (!mem_req && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("req_seen", 32'(mem_req), 32'd1);
        if (chk_tp) check("throughput", 32'(cyc - last_cyc), 32'd2);
        last_cyc = cyc;
        check("mem_addr", 32'(mem_addr), 32'(addr));
        repeat (waits) begin
            @(negedge clk);
            check("addr_hold", {26'd0, mem_req, mem_addr}, {26'd0, 1'b1, addr});
        end
        e.op  = mem[addr][7:5];
        e.opd = mem[addr][4:0];
        exp_q.push_back(e);
        mem_rdata = mem[addr];
        mem_ack   = 1'b1;
        @(negedge clk);
        mem_ack   = 1'b0;
        mem_rdata = 8'($urandom);
        e = exp_q.pop_front();
        nxt = addr + 5'd1;
        check("valid", {30'd0, instr_valid, mem_req}, 32'b10);
        check("ir", {24'd0, opcode, operand}, {24'd0, e.op, e.opd});
        check("pc_inc", 32'(pc), 32'(nxt));
        check("fault0", 32'(fault), 32'd0);
        // Spurious ack and resume while holding must be ignored.
        repeat (rdelay) begin
            mem_ack   = 1'b1;
            resume    = 1'b1;
            @(negedge clk);
            check("hold_stable", {22'd0, instr_valid, mem_req, opcode, operand},
                  {22'd0, 1'b1, 1'b0, e.op, e.opd});
        end
        mem_ack     = 1'b0;
        resume      = 1'b0;
        instr_ready = 1'b1;
        acc_zero    = acc;
        @(negedge clk);
        instr_ready = 1'b0;
        acc_zero    = ~acc;
    endtask

    initial begin
        rst_n       = 1'b0;
        mem_rdata   = '0;
        mem_ack     = 1'b0;
        instr_ready = 1'b0;
        acc_zero    = 1'b0;
        resume      = 1'b0;
        for (int i = 0; i < 32; i++) mem[i] = 8'h40 | 8'(i);
        mem[0]  = 8'h40; mem[1] = 8'h61; mem[2] = 8'h85; mem[3] = 8'hE7;
        mem[4]  = 8'h00; mem[5] = 8'hAB; mem[7] = 8'hFE;
        mem[30] = 8'h20; mem[31] = 8'h5F;

        repeat (2) @(negedge clk);
        check_all_zero("reset_vals");
        rst_n = 1'b1;
        check("idle_no_req", 32'(mem_req), 32'd0);
        @(negedge clk);
        check("first_req", 32'(mem_req), 32'd1);

        step(5'd0, 0, 0, 1'b0, 1'b0);
        step(5'd1, 0, 0, 1'b0, 1'b1);
        step(5'd2, 0, 0, 1'b0, 1'b1);
        step(5'd3, 0, 0, 1'b0, 1'b1);     // JMP 7
        step(5'd7, 0, 0, 1'b0, 1'b1);     // JMP 30
        step(5'd30, 0, 0, 1'b1, 1'b1);    // SKZ taken: 31 -> 0
        step(5'd0, 0, 0, 1'b0, 1'b1);
        step(5'd1, 2, 0, 1'b0, 1'b0);
        step(5'd2, 0, 0, 1'b0, 1'b0);
        step(5'd3, 0, 0, 1'b1, 1'b1);     // JMP, acc_zero irrelevant
        step(5'd7, 0, 0, 1'b1, 1'b1);
        step(5'd30, 0, 0, 1'b0, 1'b1);    // SKZ not taken -> 31
        step(5'd31, 0, 0, 1'b1, 1'b1);    // sequential wrap -> 0
        step(5'd0, 0, 0, 1'b0, 1'b1);
        step(5'd1, 0, 5, 1'b0, 1'b1);     // instr_ready held low 5 cycles
        mem[3] = 8'h42;
        step(5'd2, 0, 0, 1'b0, 1'b0);
        step(5'd3, 0, 0, 1'b0, 1'b1);
        step(5'd4, 0, 0, 1'b1, 1'b1);     // HLT

        for (int i = 0; i < 10; i++) begin
            check("halt_hold", {29'd0, halted, mem_req, instr_valid}, 32'b100);
            @(negedge clk);
        end
        check("halt_pc", 32'(pc), 32'd5);
        resume = 1'b1;
        @(negedge clk);
        resume = 1'b0;
        check("resumed", {30'd0, halted, mem_req}, 32'b01);
        step(5'd5, 3, 0, 1'b0, 1'b0);

        // Reset in the middle of a fetch.
        check("mid_req", {26'd0, mem_req, mem_addr}, {26'd0, 1'b1, 5'd6});
        #2 rst_n = 1'b0;
        #1 check_all_zero("mid_reset");
        @(negedge clk);
        rst_n = 1'b1;
        check("restart_idle", 32'(mem_req), 32'd0);
        @(negedge clk);
        step(5'd0, 0, 0, 1'b0, 1'b0);
        step(5'd1, 0, 0, 1'b0, 1'b1);

`ifdef FETCH_TIMEOUT_EN
        // Memory never answers: expect timeout after 15 wait cycles.
        check("to_req", 32'(mem_req), 32'd1);
        repeat (14) @(negedge clk);
        check("to_pre", {29'd0, mem_req, halted, fault}, 32'b100);
        @(negedge clk);
        check("to_fault", {29'd0, mem_req, halted, fault}, 32'b011);
        resume = 1'b1;
        @(negedge clk);
        resume = 1'b0;
        repeat (3) @(negedge clk);
        check("to_resume_ign", {29'd0, mem_req, halted, fault}, 32'b011);
`else
        repeat (40) begin
            @(negedge clk);
            if (!mem_req) break;
        end
        check("no_timeout", {30'd0, mem_req, fault}, 32'b10);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
